// File: rtl/fa_call_panel_if.sv
// rtl/fa_call_panel_if.sv - seat call panel signal bundle
// master drives the seat buttons and ack, slave (the panel) drives the lights and status.
interface fa_call_panel_if #(
  parameter int NUM_SEATS = 8
) ();
  localparam int SEAT_W = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1;
  localparam int CNT_W  = $clog2(NUM_SEATS + 1);

  logic [NUM_SEATS-1:0] call_button;
  logic [NUM_SEATS-1:0] cancel_button;
  logic                 ack;
  logic [NUM_SEATS-1:0] light_state;
  logic                 next_valid;
  logic [SEAT_W-1:0]    next_seat;
  logic [CNT_W-1:0]     pending_count;
  logic                 escalate;

  modport master (
    output call_button, cancel_button, ack,
    input  light_state, next_valid, next_seat, pending_count, escalate
  );

  modport slave (
    input  call_button, cancel_button, ack,
    output light_state, next_valid, next_seat, pending_count, escalate
  );
endinterface

// File: rtl/fa_call_panel.sv
// rtl/fa_call_panel.sv - flight attendant call panel with lowest-seat-first service
// Optional macro FA_ESCALATION_EN compiles in the unacknowledged-call timer and ESCALATED state.
module fa_call_panel #(
  parameter int NUM_SEATS  = 8,
  parameter int ESC_CYCLES = 100
) (
  input  logic             clk,
  input  logic             rst,
  fa_call_panel_if.slave   bus
);
  localparam int SEAT_W = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1;
  localparam int CNT_W  = $clog2(NUM_SEATS + 1);

  typedef enum logic [1:0] {IDLE, WAITING, ESCALATED} state_e;

  logic [NUM_SEATS-1:0] light_q, light_d;
  state_e               state_q, state_d;
  logic                 ack_hit;
  logic [SEAT_W-1:0]    seat_c;
  logic [CNT_W-1:0]     cnt_c;

  // Lowest lit seat wins, so scan downward and let the lower index overwrite.
  always_comb begin
    seat_c = '0;
    cnt_c  = '0;
    for (int i = NUM_SEATS - 1; i >= 0; i--) begin
      if (light_q[i]) seat_c = SEAT_W'(i);
      cnt_c = cnt_c + CNT_W'(light_q[i]);
    end
  end

  assign ack_hit = bus.ack && (light_q != '0);

  // Call beats cancel beats ack on the same seat.
  always_comb begin
    light_d = light_q;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (bus.call_button[i])                        light_d[i] = 1'b1;
      else if (bus.cancel_button[i])                 light_d[i] = 1'b0;
      else if (ack_hit && (seat_c == SEAT_W'(i)))    light_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) light_q <= '0;
    else     light_q <= light_d;
  end

`ifdef FA_ESCALATION_EN
  localparam int TIMER_W = $clog2(ESC_CYCLES + 1);

  logic [TIMER_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // New calls never restart the timer; only an ack or an empty panel does.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (light_d == '0) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (ack_hit) begin
      state_d = WAITING;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAITING;
          timer_d = '0;
        end
        WAITING: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TIMER_W'(ESC_CYCLES - 1)) state_d = ESCALATED;
        end
        ESCALATED: timer_d = timer_q;
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.escalate = (state_q == ESCALATED);
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (light_d != '0) ? WAITING : IDLE;
      WAITING: state_d = (light_d != '0) ? WAITING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.escalate = 1'b0;
  end
`endif

  assign bus.light_state   = light_q;
  assign bus.next_valid    = (light_q != '0);
  assign bus.next_seat     = seat_c;
  assign bus.pending_count = cnt_c;
endmodule

// File: tb/tb_fa_call_panel.sv
// tb/tb_fa_call_panel.sv - randomized self-checking bench for fa_call_panel
// A queue-free arithmetic model tracks the lights and the age of the oldest unserviced wait.
module tb_fa_call_panel;
  localparam int NS  = 4;
  localparam int ESC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  fa_call_panel_if #(.NUM_SEATS(NS)) bus_if ();

  fa_call_panel #(.NUM_SEATS(NS), .ESC_CYCLES(ESC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [NS-1:0] m_light;
  int            m_age;

  function automatic logic [NS-1:0] model_next(input logic [NS-1:0] old, input logic [NS-1:0] c,
                                               input logic [NS-1:0] x, input logic a);
    logic [NS-1:0] n;
    n = old;
    if (a && old != 0) n = n & ~(old & (~old + 1'b1));
    return (n & ~x) | c;
  endfunction

  // Age counts edges since the panel last went from empty, or was acked, with lights remaining.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_light <= '0;
      m_age   <= 0;
    end else begin
      logic [NS-1:0] nl;
      nl = model_next(m_light, bus_if.call_button, bus_if.cancel_button, bus_if.ack);
      m_light <= nl;
      if (nl == 0 || m_light == 0 || (bus_if.ack && m_light != 0)) m_age <= 0;
      else if (m_age < ESC) m_age <= m_age + 1;
    end
  end

  function automatic int exp_seat(input logic [NS-1:0] l);
    for (int i = 0; i < NS; i++) if (l[i]) return i;
    return 0;
  endfunction

  function automatic int exp_count(input logic [NS-1:0] l);
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(l[i]);
    return n;
  endfunction

  function automatic int exp_esc(input int age);
`ifdef FA_ESCALATION_EN
    return (age >= ESC) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    check("light_state",   int'(bus_if.light_state),   int'(m_light));
    check("next_valid",    int'(bus_if.next_valid),    (m_light != 0) ? 1 : 0);
    check("next_seat",     int'(bus_if.next_seat),     exp_seat(m_light));
    check("pending_count", int'(bus_if.pending_count), exp_count(m_light));
    check("escalate",      int'(bus_if.escalate),      exp_esc(m_age));
  end

  task automatic cyc(input logic [NS-1:0] c, input logic [NS-1:0] x, input logic a);
    bus_if.call_button   = c;
    bus_if.cancel_button = x;
    bus_if.ack           = a;
    @(posedge clk);
    #2;
    bus_if.call_button   = '0;
    bus_if.cancel_button = '0;
    bus_if.ack           = 1'b0;
  endtask

  initial begin
    bus_if.call_button   = '0;
    bus_if.cancel_button = '0;
    bus_if.ack           = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    repeat (10) cyc('0, '0, 1'b0);
    check("idle_light", int'(bus_if.light_state), 0);
    check("idle_valid", int'(bus_if.next_valid), 0);
    check("idle_count", int'(bus_if.pending_count), 0);
    check("idle_esc",   int'(bus_if.escalate), 0);

    cyc(4'b1010, '0, 1'b0);
    check("call_light", int'(bus_if.light_state), 4'b1010);
    check("call_seat",  int'(bus_if.next_seat), 1);
    check("call_count", int'(bus_if.pending_count), 2);
    cyc('0, '0, 1'b1);
    check("ack_light", int'(bus_if.light_state), 4'b1000);
    check("ack_seat",  int'(bus_if.next_seat), 3);
    check("ack_count", int'(bus_if.pending_count), 1);
    cyc('0, 4'b1000, 1'b0);
    cyc('0, '0, 1'b1);
    check("ack_empty_ignored", int'(bus_if.light_state), 0);

    cyc(4'b0100, 4'b0100, 1'b0);
    check("call_over_cancel", int'(bus_if.light_state), 4'b0100);
    cyc('0, 4'b0100, 1'b0);
    check("cancel_clear", int'(bus_if.light_state), 0);
    check("cancel_valid", int'(bus_if.next_valid), 0);

    cyc(4'b0001, '0, 1'b0);
    for (int k = 1; k < ESC; k++) begin
      cyc('0, '0, 1'b0);
      check("esc_early", int'(bus_if.escalate), 0);
    end
    cyc('0, '0, 1'b0);
`ifdef FA_ESCALATION_EN
    check("esc_rise", int'(bus_if.escalate), 1);
`else
    check("esc_rise", int'(bus_if.escalate), 0);
`endif
    cyc('0, '0, 1'b1);
    check("esc_ack_esc",   int'(bus_if.escalate), 0);
    check("esc_ack_light", int'(bus_if.light_state), 0);

    cyc(4'b0001, '0, 1'b1);
    check("call_over_ack", int'(bus_if.light_state), 4'b0001);
    cyc('0, 4'b0001, 1'b0);

    cyc(4'b0011, '0, 1'b0);
    repeat (12) cyc('0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_light", int'(bus_if.light_state), 0);
    check("async_rst_esc",   int'(bus_if.escalate), 0);
    check("async_rst_count", int'(bus_if.pending_count), 0);
    cyc(4'b1111, '0, 1'b0);
    check("rst_ignores_in", int'(bus_if.light_state), 0);
    rst = 1'b0;

    repeat (50) cyc(4'b1000, '0, 1'b0);
    check("held_light", int'(bus_if.light_state), 4'b1000);
`ifdef FA_ESCALATION_EN
    check("held_esc", int'(bus_if.escalate), 1);
`else
    check("held_esc", int'(bus_if.escalate), 0);
`endif
    cyc('0, 4'b1000, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      logic [NS-1:0] c, x;
      logic a;
      for (int b = 0; b < NS; b++) begin
        c[b] = ($urandom_range(0, 7) == 0);
        x[b] = (n < 1000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 31) == 0);
      end
      a = (n < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      cyc(c, x, a);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fa_call_panel.md
FA_CALL_PANEL -- requirements
Module: fa_call_panel

Interface
REQ-001 SHALL have parameter NUM_SEATS, default 8, number of independent seat call channels (legal range 2..32).
REQ-002 SHALL have parameter ESC_CYCLES, default 100, number of unacknowledged clock cycles before escalation (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port call_button  input  NUM_SEATS  per-seat call request, bit i = seat i.
REQ-006 SHALL have port cancel_button  input  NUM_SEATS  per-seat cancel request, bit i = seat i.
REQ-007 SHALL have port ack  input  1  attendant services the seat currently shown on next_seat.
REQ-008 SHALL have port light_state  output  NUM_SEATS  registered per-seat call light.
REQ-009 SHALL have port next_valid  output  1  high when any light_state bit is set.
REQ-010 SHALL have port next_seat  output  max(1,$clog2(NUM_SEATS))  index of lowest-numbered lit seat, 0 when next_valid=0.
REQ-011 SHALL have port pending_count  output  $clog2(NUM_SEATS+1)  population count of light_state.
REQ-012 SHALL have port escalate  output  1  registered, high while panel FSM is in ESCALATED.

Function
REQ-013 Per seat i, next light_state[i]: call_button[i]=1 -> 1; else cancel_button[i]=1 -> 0; else ack clearing seat i -> 0; else hold.
REQ-014 Call SHALL take priority over cancel and over ack on the same seat in the same cycle (light stays/turns on).
REQ-015 ack SHALL clear only seat next_seat, and only when next_valid=1; ack with next_valid=0 SHALL be ignored.
REQ-016 next_valid, next_seat, pending_count SHALL be combinational functions of the light_state register (zero-latency relative to light_state).
REQ-017 Panel FSM states: IDLE (no lights), WAITING (lights, timer running), ESCALATED (timer expired).
REQ-018 IDLE -> WAITING on the edge where next light_state becomes nonzero; timer loads 0.
REQ-019 In WAITING the timer SHALL increment by 1 per cycle; new calls SHALL NOT restart it.
REQ-020 WAITING -> ESCALATED when the timer reaches ESC_CYCLES-1, so escalate rises exactly ESC_CYCLES edges after the first light came on.
REQ-021 A valid ack in WAITING or ESCALATED SHALL reset the timer to 0 and go to WAITING if any light remains after the update, else IDLE.
REQ-022 Any state SHALL go to IDLE with timer 0 when next light_state is all zero (e.g. all cancelled).
REQ-023 Timer SHALL saturate in ESCALATED (no wrap); width $clog2(ESC_CYCLES+1).

Reset
REQ-024 On rst=1, immediately and independent of clk: light_state=0, FSM=IDLE, timer=0, escalate=0; hence next_valid=0, next_seat=0, pending_count=0.
REQ-025 Reset asserted mid-operation (WAITING/ESCALATED) SHALL discard all pending calls; inputs SHALL be ignored while rst=1.
REQ-026 First state update after rst deasserts SHALL occur on the next rising clk edge.

Configuration
REQ-027 Macro FA_ESCALATION_EN: when defined, timer and ESCALATED state are compiled in per REQ-017..REQ-023.
REQ-028 Without FA_ESCALATION_EN: no timer logic, FSM has only IDLE/WAITING, escalate tied 0; all other behaviour identical.

Verification (NUM_SEATS=4, ESC_CYCLES=10, FA_ESCALATION_EN defined unless stated)
REQ-029 Reset then idle 10 cycles, no inputs -> light_state=4'b0000, next_valid=0, pending_count=0, escalate=0.
REQ-030 call_button=4'b1010 one cycle -> light_state=4'b1010, next_seat=1, pending_count=2; then ack one cycle -> light_state=4'b1000, next_seat=3, pending_count=1.
REQ-031 call_button[2] and cancel_button[2] both high one cycle from empty -> light_state=4'b0100; then cancel_button[2] alone -> 4'b0000, FSM IDLE.
REQ-032 call seat 0, no ack -> escalate=0 for 9 edges after light on, escalate=1 on the 10th; ack -> escalate=0 next cycle, light_state=0.
REQ-033 lights 4'b0011 held, rst pulsed asynchronously mid-cycle -> light_state=0 and escalate=0 before next clk edge.
REQ-034 Build without FA_ESCALATION_EN, call seat 3 held unacked 50 cycles -> escalate stays 0, light_state=4'b1000.
